// File: rtl/vga_sync_decoder_if.sv
// Video-in and decode-result bundle for vga_sync_decoder.
// The slave modport is the decoder side; master is the source/consumer side.
interface vga_sync_decoder_if;
  logic        hsync;
  logic        vsync;
  logic        blank_b;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic        pix_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        frame_start;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  modport master (
    output hsync, vsync, blank_b, r, g, b,
    input  pix_r, pix_g, pix_b, pix_valid, x, y,
    input  frame_start, locked, h_err, v_err, line_len, frame_lines
  );

  modport slave (
    input  hsync, vsync, blank_b, r, g, b,
    output pix_r, pix_g, pix_b, pix_valid, x, y,
    output frame_start, locked, h_err, v_err, line_len, frame_lines
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: recovers pixel coordinates, measures line
// and frame periods against the nominal format and tracks lock.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_UNLOCKED  | no frame reference; waiting for the first vsync falling edge
// S_ACQUIRE   | measuring one whole frame; lock if every line and the frame fit
// S_LOCKED    | timing verified; deviations raise h_err / v_err
module vga_sync_decoder #(
  parameter int HMAX    = 800,
  parameter int VMAX    = 525,
  parameter int TIMEOUT = 1600
) (
  input  logic              vgaclk,
  input  logic              reset,
  vga_sync_decoder_if.slave vga
);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  localparam logic [10:0] C_HMAX    = 11'(HMAX);
  localparam logic [9:0]  C_VMAX    = 10'(VMAX);
  localparam logic [10:0] C_TIMEOUT = 11'(TIMEOUT - 1);
  localparam logic [10:0] C_HSAT    = 11'h7FF;

  // stage 1: pin capture; stage 2: previous sync/blank for edge detect
  logic        r_hs1, r_vs1, r_bl1;
  logic [7:0]  r_r1, r_g1, r_b1;
  logic        r_hs2, r_vs2, r_bl2;

  logic [10:0] r_hcnt;
  logic [9:0]  r_lcnt;
  logic        r_hvalid;
  logic        r_bad;
  logic [9:0]  r_xcnt;
  logic [9:0]  r_ycnt;

  state_t      r_state;
  state_t      w_next;
  logic        w_h_err;
  logic        w_v_err;

  logic [7:0]  r_pix_r, r_pix_g, r_pix_b;
  logic        r_pix_valid;
  logic [9:0]  r_x, r_y;
  logic        r_frame_start;
  logic        r_locked;
  logic        r_h_err, r_v_err;
  logic [10:0] r_line_len;
  logic [9:0]  r_frame_lines;

  logic        w_hfall, w_vfall, w_bfall;
  logic [10:0] w_period;
  logic        w_hchk;
  logic        w_hbad;
  logic        w_timeout;
  logic [9:0]  w_frame_cnt;
  logic        w_vbad;

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_hs1 <= 1'b0;
      r_vs1 <= 1'b0;
      r_bl1 <= 1'b0;
      r_r1  <= 8'd0;
      r_g1  <= 8'd0;
      r_b1  <= 8'd0;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
      r_bl2 <= 1'b0;
    end else begin
      r_hs1 <= vga.hsync;
      r_vs1 <= vga.vsync;
      r_bl1 <= vga.blank_b;
      r_r1  <= vga.r;
      r_g1  <= vga.g;
      r_b1  <= vga.b;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_bl2 <= r_bl1;
    end
  end

  assign w_hfall = r_hs2 & ~r_hs1;
  assign w_vfall = r_vs2 & ~r_vs1;
  assign w_bfall = r_bl2 & ~r_bl1;

  assign w_period    = r_hcnt + 11'd1;
  assign w_hchk      = w_hfall & r_hvalid;
  assign w_hbad      = w_hchk & (w_period != C_HMAX);
  // hcnt only passes TIMEOUT-1 once per missing-hsync stretch, so this fires once
  assign w_timeout   = (r_hcnt == C_TIMEOUT) & ~w_hfall;
  // an hsync edge coincident with vsync belongs to the frame that is ending
  assign w_frame_cnt = r_lcnt + {9'd0, w_hfall};
  assign w_vbad      = (w_frame_cnt != C_VMAX);

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_hcnt        <= 11'd0;
      r_hvalid      <= 1'b0;
      r_line_len    <= 11'd0;
      r_lcnt        <= 10'd0;
      r_frame_lines <= 10'd0;
      r_bad         <= 1'b0;
    end else begin
      if (w_hfall) begin
        r_hcnt <= 11'd0;
      end else if (r_hcnt != C_HSAT) begin
        r_hcnt <= r_hcnt + 11'd1;
      end

      if (w_timeout) begin
        r_hvalid <= 1'b0;
      end else if (w_hfall) begin
        r_hvalid <= 1'b1;
      end

      if (w_hchk) begin
        r_line_len <= w_period;
      end

      if (w_vfall) begin
        r_lcnt        <= 10'd0;
        r_frame_lines <= w_frame_cnt;
      end else if (w_hfall) begin
        r_lcnt <= r_lcnt + 10'd1;
      end

      if (w_vfall) begin
        r_bad <= 1'b0;
      end else if (w_hbad) begin
        r_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_state <= S_UNLOCKED;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_h_err = 1'b0;
    w_v_err = 1'b0;
    unique case (r_state)
      S_UNLOCKED: begin
        if (w_vfall) begin
          w_next = S_ACQUIRE;
        end
      end
      S_ACQUIRE: begin
        if (w_vfall && !(r_bad || w_hbad) && r_hvalid && !w_vbad) begin
          w_next = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_hbad) begin
          w_h_err = 1'b1;
          w_next  = S_ACQUIRE;
        end
        if (w_vfall && w_vbad) begin
          w_v_err = 1'b1;
          w_next  = S_ACQUIRE;
        end
      end
      default: begin
        w_next = S_UNLOCKED;
      end
    endcase
    if (w_timeout) begin
      w_next = S_UNLOCKED;
      if (r_state == S_LOCKED) begin
        w_h_err = 1'b1;
      end
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_locked      <= 1'b0;
      r_h_err       <= 1'b0;
      r_v_err       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_locked      <= (r_state == S_LOCKED);
      r_h_err       <= w_h_err;
      r_v_err       <= w_v_err;
      r_frame_start <= w_vfall;
    end
  end

  // y advances at the end of each active line, so row 0 follows vsync
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      r_xcnt      <= 10'd0;
      r_ycnt      <= 10'd0;
      r_x         <= 10'd0;
      r_y         <= 10'd0;
      r_pix_r     <= 8'd0;
      r_pix_g     <= 8'd0;
      r_pix_b     <= 8'd0;
      r_pix_valid <= 1'b0;
    end else begin
      if (r_bl1) begin
        r_xcnt <= r_xcnt + 10'd1;
      end else begin
        r_xcnt <= 10'd0;
      end

      if (w_vfall) begin
        r_ycnt <= 10'd0;
      end else if (w_bfall) begin
        r_ycnt <= r_ycnt + 10'd1;
      end

      r_x         <= r_bl1 ? r_xcnt : 10'd0;
      r_y         <= r_ycnt;
      r_pix_r     <= r_bl1 ? r_r1 : 8'd0;
      r_pix_g     <= r_bl1 ? r_g1 : 8'd0;
      r_pix_b     <= r_bl1 ? r_b1 : 8'd0;
      r_pix_valid <= r_bl1 & r_locked;
    end
  end

  assign vga.pix_r       = r_pix_r;
  assign vga.pix_g       = r_pix_g;
  assign vga.pix_b       = r_pix_b;
  assign vga.pix_valid   = r_pix_valid;
  assign vga.x           = r_x;
  assign vga.y           = r_y;
  assign vga.frame_start = r_frame_start;
  assign vga.locked      = r_locked;
  assign vga.h_err       = r_h_err;
  assign vga.v_err       = r_v_err;
  assign vga.line_len    = r_line_len;
  assign vga.frame_lines = r_frame_lines;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled 40x20 timing so whole frames stay short.
module tb_vga_sync_decoder;
  localparam int HMAX    = 40;
  localparam int VMAX    = 20;
  localparam int TIMEOUT = 80;
  localparam int HACT = 24, HFP = 4, HSW = 6, HBP = 6;
  localparam int VSW  = 2,  VBP = 4, VACT = 12;
  localparam int LEAD = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_decoder_if vif ();

  vga_sync_decoder #(.HMAX(HMAX), .VMAX(VMAX), .TIMEOUT(TIMEOUT)) dut (
    .vgaclk (clk),
    .reset  (rst),
    .vga    (vif)
  );

  typedef struct {
    int          due;
    bit          valid;
    int          x;
    int          y;
    bit          chk_y;
    logic [23:0] rgb;
  } sb_t;

  typedef struct {
    int nl;
    int short_ln;
    int sbv;
    int exp_locked;
    int exp_herr;
    int exp_verr;
    int exp_fl;
    int exp_llmin;
  } vec_t;

  sb_t  q[$];
  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  bit   layout_b = 1'b0;
  int   herr_n = 0, verr_n = 0, fs_n = 0;
  int   llmin = 4095;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic cycle(input logic hs, input logic vs, input logic bl,
                       input logic [23:0] rgb, input bit push, input sb_t e);
    sb_t c;
    sb_t n;
    @(negedge clk);
    ncyc++;
    herr_n += int'(vif.h_err);
    verr_n += int'(vif.v_err);
    fs_n   += int'(vif.frame_start);
    if (vif.line_len != 11'd0 && int'(vif.line_len) < llmin) llmin = int'(vif.line_len);
    while (q.size() > 0 && q[0].due <= ncyc) begin
      c = q.pop_front();
      chk("sb_due", ncyc, c.due);
      chk("pix_valid", int'(vif.pix_valid), int'(c.valid));
      chk("pix_x", int'(vif.x), c.x);
      if (c.chk_y) chk("pix_y", int'(vif.y), c.y);
      chk("pix_rgb", int'({vif.pix_r, vif.pix_g, vif.pix_b}), int'(c.rgb));
    end
    vif.hsync   = hs;
    vif.vsync   = vs;
    vif.blank_b = bl;
    {vif.r, vif.g, vif.b} = rgb;
    if (push) begin
      n = e;
      n.due = ncyc + 2;
      q.push_back(n);
    end
  endtask

  task automatic drive_px(input int v, input int h, input int sbv);
    logic        hs, vs, act, act_line;
    logic [23:0] rgb;
    int          ast, xx, yy;
    sb_t         e;
    vs = (v >= VSW);
    if (layout_b) begin
      hs  = (h >= HSW);
      ast = HSW + HBP;
    end else begin
      hs  = !(h >= HACT + HFP && h < HACT + HFP + HSW);
      ast = 0;
    end
    act_line = (v >= VSW + VBP) && (v < VSW + VBP + VACT);
    yy  = v - (VSW + VBP);
    xx  = h - ast;
    act = act_line && (h >= ast) && (h < ast + HACT);
    rgb = (act && xx == 0 && yy == 0) ? 24'h123456 : 24'($urandom);
    e.due   = 0;
    e.valid = act && (sbv == 1);
    e.x     = act ? xx : 0;
    e.y     = yy;
    e.chk_y = act;
    e.rgb   = act ? rgb : 24'h0;
    cycle(hs, vs, act, rgb, (sbv != 0) && (act || (act_line && h == ast + HACT)), e);
  endtask

  task automatic lead();
    for (int h = 0; h < LEAD; h++) drive_px(0, h, 0);
  endtask

  task automatic body(input int nl, input int short_ln, input int sbv, input int stop);
    int n = 0;
    int len;
    for (int v = 0; v < nl; v++) begin
      len = (v == short_ln) ? HMAX - 1 : HMAX;
      for (int h = (v == 0) ? LEAD : 0; h < len; h++) begin
        if (stop > 0 && n >= stop) return;
        drive_px(v, h, sbv);
        n++;
      end
    end
  endtask

  task automatic idle(input int n);
    sb_t e;
    e = '{0, 1'b0, 0, 0, 1'b0, 24'h0};
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0, e);
  endtask

  task automatic snap(input string tag, input int el, input int eh, input int ev,
                      input int efs, input int efl, input int ell);
    chk({tag, "_locked"}, int'(vif.locked), el);
    chk({tag, "_herr_pulses"}, herr_n, eh);
    chk({tag, "_verr_pulses"}, verr_n, ev);
    chk({tag, "_frame_start_pulses"}, fs_n, efs);
    if (efl >= 0) chk({tag, "_frame_lines"}, int'(vif.frame_lines), efl);
    if (ell >= 0) chk({tag, "_min_line_len"}, llmin, ell);
    herr_n = 0;
    verr_n = 0;
    fs_n   = 0;
    llmin  = 4095;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      body(vecs[i].nl, vecs[i].short_ln, vecs[i].sbv, 0);
      lead();
      snap($sformatf("vec%0d", i), vecs[i].exp_locked, vecs[i].exp_herr,
           vecs[i].exp_verr, 1, vecs[i].exp_fl, vecs[i].exp_llmin);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, int'(vif.locked), 0);
    chk({tag, "_pix_valid"}, int'(vif.pix_valid), 0);
    chk({tag, "_x"}, int'(vif.x), 0);
    chk({tag, "_y"}, int'(vif.y), 0);
    chk({tag, "_rgb"}, int'({vif.pix_r, vif.pix_g, vif.pix_b}), 0);
    chk({tag, "_line_len"}, int'(vif.line_len), 0);
    chk({tag, "_frame_lines"}, int'(vif.frame_lines), 0);
    chk({tag, "_pulses"}, int'({vif.frame_start, vif.h_err, vif.v_err}), 0);
  endtask

  initial begin
    // nl, short line, pixel check (0 none, 1 valid, 2 not valid), then state after the frame
    vecs[0]  = '{20, -1, 2, 1, 0, 0, 20, 40};
    vecs[1]  = '{20, -1, 1, 1, 0, 0, 20, 40};
    vecs[2]  = '{20,  8, 0, 0, 1, 0, 20, 39};
    vecs[3]  = '{20, -1, 2, 1, 0, 0, 20, 40};
    vecs[4]  = '{19, -1, 1, 0, 0, 1, 19, 40};
    vecs[5]  = '{20, -1, 2, 1, 0, 0, 20, 40};
    vecs[6]  = '{20, -1, 1, 1, 0, 0, 20, 40};
    vecs[7]  = '{20, -1, 2, 1, 0, 0, 20, 40};
    vecs[8]  = '{20, -1, 1, 1, 0, 0, 20, 40};
    vecs[9]  = '{20, -1, 2, 1, 0, 0, 20, 40};
    vecs[10] = '{20, -1, 1, 1, 0, 0, 20, 40};

    vif.hsync   = 1'b1;
    vif.vsync   = 1'b1;
    vif.blank_b = 1'b0;
    {vif.r, vif.g, vif.b} = 24'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    idle(5);
    lead();
    snap("first_vfall", 0, 0, 0, 1, -1, -1);
    run(0, 6);

    idle(2 * TIMEOUT);
    snap("timeout", 0, 1, 0, 0, -1, -1);
    lead();
    snap("restore_vfall", 0, 0, 0, 1, -1, -1);
    run(7, 8);

    body(20, -1, 0, (VSW + VBP + 2) * HMAX + 15 - LEAD);
    chk("pre_reset_locked", int'(vif.locked), 1);
    chk("pre_reset_pix_valid", int'(vif.pix_valid), 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_reset");
    herr_n = 0;
    verr_n = 0;
    fs_n   = 0;
    llmin  = 4095;

    layout_b = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    lead();
    snap("b_first_vfall", 0, 0, 0, 1, -1, -1);
    run(9, 10);

    idle(3);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: samples hsync, vsync, blank_b and 24-bit RGB on the pixel clock.
- Recovers pixel coordinates and verifies line and frame timing against the 640x480@60 format.
- Reports lock and timing errors.
- Used as a loopback checker / frame-capture front end in the final project.

Parameters:
- HMAX, 800, expected pixel clocks per line (hsync falling edge to hsync falling edge).
- VMAX, 525, expected hsync falling edges per frame (vsync falling edge to vsync falling edge).
- TIMEOUT, 1600, clocks without an hsync falling edge before dropping to UNLOCKED.

Ports:
- vgaclk  in  1  pixel clock (25.175 MHz).
- reset  in  1  asynchronous, active-high.
- hsync  in  1  horizontal sync, active low.
- vsync  in  1  vertical sync, active low.
- blank_b  in  1  high during the active area.
- r, g, b  in  8 each  pixel colour.
- pix_r, pix_g, pix_b  out  8 each  registered pixel colour.
- pix_valid  out  1  pixel on pix_* is active and decoder is locked.
- x  out  10  column of the current pix_* pixel.
- y  out  10  row of the current pix_* pixel.
- frame_start  out  1  one-cycle pulse on each vsync falling edge.
- locked  out  1  high in LOCKED state.
- h_err  out  1  one-cycle pulse on line-period error or timeout.
- v_err  out  1  one-cycle pulse on frame line-count error.
- line_len  out  11  last measured line period.
- frame_lines  out  10  last measured frame line count.

Behaviour:
- Reset: all outputs 0, state UNLOCKED, counters 0, hvalid 0.
- Reset is asynchronous and active-high. Asserting it mid-frame aborts immediately; after release, decoding restarts from UNLOCKED.
- Input stage: all inputs registered once (stage 1).
  - Edges are detected against a second registered copy of hsync, vsync and blank_b.
  - hfall = prev 1, now 0 (hsync). vfall likewise for vsync. bfall likewise for blank_b.
- Output stage: pix_*, pix_valid, x and y are registered from stage 1. Total latency from input pins to pix_* is 2 cycles.
- hcnt (11-bit, saturating at 2047):
  - Set to 0 on hfall, else incremented.
  - On hfall with hvalid=1: period = hcnt+1 is loaded into line_len.
  - On hfall: hvalid is set to 1.
- lcnt (10-bit):
  - Incremented on hfall; zeroed on vfall.
  - On vfall: frame_lines = lcnt + hfall (a simultaneous hfall counts toward the ending frame). lcnt then becomes 0.
- x: 0 while blank_b is low; increments by 1 on each active cycle. x = 0 for the first active pixel of a line.
- y:
  - Zeroed on vfall.
  - Increments on bfall (end of an active line), so y = 0 on the first active line after vsync.
  - Wraps modulo 1024.
- pix_valid = stage-1 blank_b AND locked.
- pix_* always carry the registered input colour. They are zeroed when stage-1 blank_b is low.
- FSM:
  - UNLOCKED -> ACQUIRE on vfall. The frame check is skipped on this edge.
  - ACQUIRE:
    - A per-frame bad flag is set by any checked period != HMAX.
    - On vfall: if bad=0, hvalid=1 and frame_lines == VMAX, go to LOCKED; otherwise stay in ACQUIRE and clear bad.
    - No error pulses are issued in ACQUIRE.
  - LOCKED:
    - Checked period != HMAX -> h_err pulse, go to ACQUIRE.
    - vfall with frame_lines != VMAX -> v_err pulse, go to ACQUIRE.
    - Both in the same cycle -> both pulses, go to ACQUIRE.
  - Any state: hcnt reaching TIMEOUT-1 -> go to UNLOCKED and clear hvalid. h_err pulses if the prior state was LOCKED. The timeout fires once until the next hfall.
- frame_start pulses on every vfall regardless of state.
- locked is a registered copy of the state being LOCKED. It updates the cycle after the transition decision.

Test Plan:
- Reset, then two full frames from a reference vgaController (800x525) -> locked rises one cycle after the second vfall; line_len=800, frame_lines=525; no h_err or v_err.
- Locked stream, first active pixel of line 0 with RGB=0x123456 -> 2 cycles later: pix_valid=1, x=0, y=0, pix_r=0x12, pix_g=0x34, pix_b=0x56. Last active pixel of line 479 -> x=639, y=479.
- While locked, one line shortened to 799 clocks -> line_len=799; one h_err pulse; locked=0; relock after the next clean full frame.
- While locked, a frame of 524 lines -> frame_lines=524; one v_err pulse; ACQUIRE; relock after the next clean frame.
- While locked, hsync held high for 1600 clocks -> state UNLOCKED; one h_err pulse; locked=0. Restored input -> relock after two vfalls.
- Assert reset mid-line while locked -> all outputs 0 immediately. hsync and vsync falling in the same cycle -> that edge is counted in frame_lines (525 for a nominal frame).
